// File: rtl/mips16_mc_ctrl.sv
// Multicycle control FSM for the MIPS-16 datapath: sequences each instruction,
// waits on mem_ready with a bounded timeout and drives the datapath enables.
module mips16_mc_ctrl #(
  parameter int unsigned ALUOP_W = 2,
  parameter int unsigned TMO_W   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [2:0]         op,
  input  logic               select,
  input  logic               mem_ready,
  output logic               pcwrite,
  output logic               branch,
  output logic               iord,
  output logic               memread,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               link,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [ALUOP_W-1:0] aluop,
  output logic               bus_err,
  output logic [3:0]         state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEX   = 4'd6,
    S_IMMEX  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10
  } state_t;

  localparam logic [ALUOP_W-1:0] ALU_ADD = '0;
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_RT  = ALUOP_W'(3);
  localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [TMO_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         op_q;
  logic               sel_q;
  logic               bus_err_q, bus_err_d;
  logic               waiting;

  logic               pcwrite_c, branch_c, iord_c, memread_c, memwrite_c, irwrite_c;
  logic               regwrite_c, regdst_c, memtoreg_c, link_c, alusrca_c;
  logic [1:0]         alusrcb_c, pcsrc_c;
  logic [ALUOP_W-1:0] aluop_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      op_q      <= '0;
      sel_q     <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
      if (state_q == S_DECODE) begin
        op_q  <= op;
        sel_q <= select;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bus_err_d  = bus_err_q;
    waiting    = 1'b0;
    pcwrite_c  = 1'b0;
    branch_c   = 1'b0;
    iord_c     = 1'b0;
    memread_c  = 1'b0;
    memwrite_c = 1'b0;
    irwrite_c  = 1'b0;
    regwrite_c = 1'b0;
    regdst_c   = 1'b0;
    memtoreg_c = 1'b0;
    link_c     = 1'b0;
    alusrca_c  = 1'b0;
    alusrcb_c  = 2'b00;
    pcsrc_c    = 2'b00;
    aluop_c    = ALU_ADD;

    case (state_q)
      S_FETCH: begin
        if (run) begin
          memread_c = 1'b1;
          alusrcb_c = 2'b01;
          irwrite_c = mem_ready;
          pcwrite_c = mem_ready;
          if (mem_ready) state_d = S_DECODE;
          else           waiting = 1'b1;
        end else begin
          cnt_d = '0;
        end
      end
      S_DECODE: begin
        alusrcb_c = 2'b11;
        case (op)
          3'b000:         state_d = S_FETCH;
          3'b001:         state_d = S_RTEX;
          3'b010, 3'b011: state_d = S_IMMEX;
          3'b100:         state_d = S_MEMADR;
          3'b101:         state_d = S_BRANCH;
          default:        state_d = S_JUMP;
        endcase
      end
      S_MEMADR: begin
        alusrca_c = 1'b1;
        alusrcb_c = 2'b10;
        state_d   = sel_q ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        memread_c = 1'b1;
        iord_c    = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
        else           waiting = 1'b1;
      end
      S_MEMWB: begin
        regwrite_c = 1'b1;
        memtoreg_c = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        memwrite_c = 1'b1;
        iord_c     = 1'b1;
        if (mem_ready) state_d = S_FETCH;
        else           waiting = 1'b1;
      end
      S_RTEX: begin
        alusrca_c = 1'b1;
        aluop_c   = ALU_RT;
        state_d   = S_ALUWB;
      end
      S_IMMEX: begin
        alusrca_c = 1'b1;
        alusrcb_c = 2'b10;
        aluop_c   = (op_q == 3'b011) ? ALU_SUB : ALU_ADD;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite_c = 1'b1;
        regdst_c   = (op_q == 3'b001);
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alusrca_c = 1'b1;
        aluop_c   = ALU_SUB;
        branch_c  = 1'b1;
        pcsrc_c   = 2'b01;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pcwrite_c = 1'b1;
        if (op_q == 3'b110 && !sel_q) begin
          pcsrc_c = 2'b10;
        end else begin
          pcsrc_c = 2'b11;
          if (op_q == 3'b110) begin
            link_c     = 1'b1;
            regwrite_c = 1'b1;
          end
        end
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // a timeout in FETCH stays in FETCH, so the counter is cleared explicitly there too
    if (waiting) begin
      if (cnt_q == TMO_LAST) begin
        bus_err_d = 1'b1;
        state_d   = S_FETCH;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (state_d != state_q) cnt_d = '0;
  end

  // outputs forced low while reset is held, even though FETCH decoding would drive memread
  assign pcwrite  = rst_n & pcwrite_c;
  assign branch   = rst_n & branch_c;
  assign iord     = rst_n & iord_c;
  assign memread  = rst_n & memread_c;
  assign memwrite = rst_n & memwrite_c;
  assign irwrite  = rst_n & irwrite_c;
  assign regwrite = rst_n & regwrite_c;
  assign regdst   = rst_n & regdst_c;
  assign memtoreg = rst_n & memtoreg_c;
  assign link     = rst_n & link_c;
  assign alusrca  = rst_n & alusrca_c;
  assign alusrcb  = rst_n ? alusrcb_c : '0;
  assign pcsrc    = rst_n ? pcsrc_c : '0;
  assign aluop    = rst_n ? aluop_c : '0;
  assign bus_err  = rst_n & bus_err_q;
  assign state    = rst_n ? state_q : '0;

endmodule
